mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage load/store) port. It sequences each access through issue, wait and completion, returns read data and a completion pulse to the winning requester, and holds the other off so the pipeline stalls on it. Data accesses win contention, but IF is guaranteed progress by a streak limit. Fetch is cancellable on branch, jump or interrupt redirect.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_streak_ctr.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Wide enough for MEM_LAT and MAX_STREAK up to 15
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Grant-select decision plus the saturating counter that bounds IF starvation.
module arb_streak_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arb_en,
    input  logic                if_elig,
    input  logic                d_elig,
    output logic                grant_c,
    output logic                grant_port_c,
    output logic [STREAK_W-1:0] streak
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic at_max;

    assign at_max = (streak == STREAK_MAX);

    // Data wins contention unless IF has already lost MAX_STREAK times in a row
    always_comb begin
        grant_c      = arb_en & (if_elig | d_elig);
        grant_port_c = PORT_D;
        if (if_elig && (!d_elig || at_max)) begin
            grant_port_c = PORT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_c) begin
            if (grant_port_c == PORT_IF) begin
                streak <= '0;
            end else if (if_elig && !at_max) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                if_cancel_q;
    logic                d_we_q;
    logic                if_elig;
    logic                d_elig;
    logic                arb_en;
    logic                grant_c;
    logic                grant_port_c;
    logic                capture_c;
    logic [STREAK_W-1:0] streak;

    // A port whose done pulse is showing sits out this arbitration round
    assign if_elig   = if_req & ~if_flush & ~if_done;
    assign d_elig    = d_req & ~d_done;
    assign arb_en    = reset & (state_q == IDLE);
    assign capture_c = (state_q != IDLE) && (cnt_q == '0);

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk          (clk),
        .reset        (reset),
        .arb_en       (arb_en),
        .if_elig      (if_elig),
        .d_elig       (d_elig),
        .grant_c      (grant_c),
        .grant_port_c (grant_port_c),
        .streak       (streak)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d = (grant_port_c == PORT_IF) ? BUSY_IF : BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (capture_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobe is issued in the grant cycle itself, operands from the winner
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_c) begin
            mem_en = 1'b1;
            if (grant_port_c == PORT_IF) begin
                mem_addr = if_addr & WORD_MASK;
            end else begin
                mem_we    = d_we;
                mem_addr  = d_addr & WORD_MASK;
                mem_wdata = d_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            if_cancel_q <= 1'b0;
            d_we_q      <= 1'b0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;

            if (grant_c) begin
                cnt_q  <= CNT_W'(MEM_LAT - 1);
                d_we_q <= (grant_port_c == PORT_D) & d_we;
            end else if (state_q != IDLE && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // A flush anywhere up to the capture cycle suppresses the fetch result
            if (state_q == BUSY_IF) begin
                if (capture_c) begin
                    if_cancel_q <= 1'b0;
                    if (!if_cancel_q && !if_flush) begin
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end else if (if_flush) begin
                    if_cancel_q <= 1'b1;
                end
            end

            if (state_q == BUSY_D && capture_c) begin
                d_done <= 1'b1;
                if (!d_we_q) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expectations, a monitor checks them.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned MAX_STREAK = 4;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    exp_t exp_mem[$];
    exp_t exp_if[$];
    exp_t exp_d[$];

    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] rd_pipe [MEM_LAT];
    logic [31:0] last_load;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Fixed-latency memory model; non-read cycles return a poison value
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_store[mem_addr] = mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_mem(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.data = wd;
        exp_mem.push_back(e);
    endtask

    task automatic push_if(input int c, input logic [31:0] rd);
        exp_t e;
        e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = rd;
        exp_if.push_back(e);
    endtask

    task automatic push_d(input int c, input logic [31:0] rd);
        exp_t e;
        e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = rd;
        exp_d.push_back(e);
    endtask

    // Monitor: every strobe or done pulse must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (mem_en) begin
            vectors++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_en: unexpected access at cycle %0d addr %h we %b", cyc, mem_addr, mem_we);
            end else begin
                e = exp_mem.pop_front();
                if (e.cyc != cyc || e.we !== mem_we || e.addr !== mem_addr || e.data !== mem_wdata) begin
                    errors++;
                    $display("FAIL mem_access: got cyc %0d we %b addr %h wdata %h expected cyc %0d we %b addr %h wdata %h",
                             cyc, mem_we, mem_addr, mem_wdata, e.cyc, e.we, e.addr, e.data);
                end
            end
        end
        if (if_done) begin
            vectors++;
            if (exp_if.size() == 0) begin
                errors++;
                $display("FAIL if_done: unexpected pulse at cycle %0d rdata %h", cyc, if_rdata);
            end else begin
                e = exp_if.pop_front();
                if (e.cyc != cyc || e.data !== if_rdata) begin
                    errors++;
                    $display("FAIL if_done: got cyc %0d rdata %h expected cyc %0d rdata %h", cyc, if_rdata, e.cyc, e.data);
                end
            end
        end
        if (d_done) begin
            vectors++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL d_done: unexpected pulse at cycle %0d rdata %h", cyc, d_rdata);
            end else begin
                e = exp_d.pop_front();
                if (e.cyc != cyc || e.data !== d_rdata) begin
                    errors++;
                    $display("FAIL d_done: got cyc %0d rdata %h expected cyc %0d rdata %h", cyc, d_rdata, e.cyc, e.data);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_if_done"},   32'(if_done),  32'h0);
        check({tag, "_d_done"},    32'(d_done),   32'h0);
        check({tag, "_mem_en"},    32'(mem_en),   32'h0);
        check({tag, "_mem_we"},    32'(mem_we),   32'h0);
        check({tag, "_mem_addr"},  mem_addr,      32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,     32'h0);
        check({tag, "_if_rdata"},  if_rdata,      32'h0);
        check({tag, "_d_rdata"},   d_rdata,       32'h0);
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        last_load = 32'h0;
        mem_store[32'h0040_0004] = 32'h8C08_0000;

        goto(2);
        @(negedge clk);
        check_idle_outputs("reset");
        goto(3);
        reset = 1'b1;

        // Lone fetch
        goto(5);
        if_req = 1'b1; if_addr = 32'h0040_0004;
        push_mem(5, 1'b0, 32'h0040_0004, 32'h0);
        push_if(8, 32'h8C08_0000);
        goto(9);
        if_req = 1'b0;

        // Contention: data first, IF in data's done cycle
        goto(12);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0010;
        if_req = 1'b1; if_addr = 32'h0040_0008;
        push_mem(12, 1'b0, 32'h1000_0010, 32'h0);
        push_d(15, 32'h1000_0010 ^ 32'h5A5A_0000);
        push_mem(15, 1'b0, 32'h0040_0008, 32'h0);
        push_if(18, 32'h0040_0008 ^ 32'h5A5A_0000);
        last_load = 32'h1000_0010 ^ 32'h5A5A_0000;
        goto(16);
        d_req = 1'b0;
        goto(19);
        if_req = 1'b0;

        // Flush during BUSY_IF; pending data granted as FSM returns to IDLE
        goto(22);
        if_req = 1'b1; if_addr = 32'h0040_0010;
        push_mem(22, 1'b0, 32'h0040_0010, 32'h0);
        goto(23);
        if_flush = 1'b1; d_req = 1'b1; d_addr = 32'h1000_0020;
        goto(24);
        if_flush = 1'b0; if_req = 1'b0;
        push_mem(25, 1'b0, 32'h1000_0020, 32'h0);
        push_d(28, 32'h1000_0020 ^ 32'h5A5A_0000);
        last_load = 32'h1000_0020 ^ 32'h5A5A_0000;
        goto(29);
        d_req = 1'b0;

        // Flush in the capture cycle
        goto(32);
        if_req = 1'b1; if_addr = 32'h0040_0014;
        push_mem(32, 1'b0, 32'h0040_0014, 32'h0);
        goto(34);
        if_flush = 1'b1;
        goto(35);
        if_flush = 1'b0; if_req = 1'b0;

        // Flush coinciding with a request blocks that grant
        goto(38);
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h0040_0018;
        goto(39);
        if_flush = 1'b0;
        push_mem(39, 1'b0, 32'h0040_0018, 32'h0);
        push_if(42, 32'h0040_0018 ^ 32'h5A5A_0000);
        goto(43);
        if_req = 1'b0;

        // Store: aligned address, d_rdata keeps last load value
        goto(46);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0007; d_wdata = 32'hDEAD_BEEF;
        push_mem(46, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        push_d(49, last_load);
        goto(50);
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        goto(52);
        d_req = 1'b1; d_addr = 32'h1001_0004;
        push_mem(52, 1'b0, 32'h1001_0004, 32'h0);
        push_d(55, 32'hDEAD_BEEF);
        last_load = 32'hDEAD_BEEF;
        goto(56);
        d_req = 1'b0;

        // Starvation: IF loses MAX_STREAK contested rounds, then wins
        push_mem(60, 1'b0, 32'h1000_0030, 32'h0);
        push_mem(64, 1'b0, 32'h1000_0030, 32'h0);
        push_mem(68, 1'b0, 32'h1000_0030, 32'h0);
        push_mem(72, 1'b0, 32'h1000_0030, 32'h0);
        push_mem(76, 1'b0, 32'h0040_001C, 32'h0);
        push_mem(79, 1'b0, 32'h1000_0030, 32'h0);
        push_d(63, 32'h1000_0030 ^ 32'h5A5A_0000);
        push_d(67, 32'h1000_0030 ^ 32'h5A5A_0000);
        push_d(71, 32'h1000_0030 ^ 32'h5A5A_0000);
        push_d(75, 32'h1000_0030 ^ 32'h5A5A_0000);
        push_d(82, 32'h1000_0030 ^ 32'h5A5A_0000);
        push_if(79, 32'h0040_001C ^ 32'h5A5A_0000);
        for (int c = 60; c <= 83; c++) begin
            goto(c);
            if (c == 60) begin
                d_req = 1'b1; d_addr = 32'h1000_0030;
                if_req = 1'b1; if_addr = 32'h0040_001C;
            end
            // Keep IF out of the data done-cycle so every round is contested
            if_flush = d_done;
            if (c == 80) if_req = 1'b0;
            if (c == 83) d_req = 1'b0;
            if (c == 76) begin
                @(negedge clk);
                check("streak_at_max", 32'(dut.u_streak.streak), 32'd4);
            end
            if (c == 77) begin
                @(negedge clk);
                check("streak_cleared", 32'(dut.u_streak.streak), 32'd0);
            end
        end
        if_flush = 1'b0;
        last_load = 32'h1000_0030 ^ 32'h5A5A_0000;

        // Reset during BUSY_D abandons the access
        goto(88);
        d_req = 1'b1; d_addr = 32'h1000_0040;
        push_mem(88, 1'b0, 32'h1000_0040, 32'h0);
        goto(89);
        reset = 1'b0; d_req = 1'b0;
        goto(90);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
        check("post_reset_streak", 32'(dut.u_streak.streak), 32'd0);
        goto(92);
        d_req = 1'b1; d_addr = 32'h1000_0044;
        push_mem(92, 1'b0, 32'h1000_0044, 32'h0);
        push_d(95, 32'h1000_0044 ^ 32'h5A5A_0000);
        goto(96);
        d_req = 1'b0;
        goto(102);

        while (exp_mem.size() != 0) begin
            exp_t e = exp_mem.pop_front();
            vectors++; errors++;
            $display("FAIL mem_access: missing access expected at cycle %0d addr %h", e.cyc, e.addr);
        end
        while (exp_if.size() != 0) begin
            exp_t e = exp_if.pop_front();
            vectors++; errors++;
            $display("FAIL if_done: missing pulse expected at cycle %0d rdata %h", e.cyc, e.data);
        end
        while (exp_d.size() != 0) begin
            exp_t e = exp_d.pop_front();
            vectors++; errors++;
            $display("FAIL d_done: missing pulse expected at cycle %0d rdata %h", e.cyc, e.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
